// File: rtl/lc3b_types.sv
// Shared types and address-split constants for the LC-3b L1 cache.
package lc3b_types;

    localparam int CACHE_OFFSET_W = 4;
    localparam int CACHE_INDEX_W  = 5;
    localparam int CACHE_TAG_W    = 7;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

endpackage

// File: rtl/lc3b_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module lc3b_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold at all-ones, zero on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_cache_control.sv
// Control FSM for the direct-mapped write-back LC-3b L1 cache: hit/miss
// decision, array write enables, writeback/fill sequencing, statistics.
module lc3b_cache_control
    import lc3b_types::*;
#(
    parameter int TAG_W = CACHE_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    input  logic [TAG_W-1:0] tag_out,
    input  logic             valid_out,
    input  logic             dirty_out,
    input  logic             pmem_resp,
    input  logic             stat_clear,
    output logic             mem_resp,
    output logic             data_write,
    output logic             tag_write,
    output logic             valid_write,
    output logic             dirty_write,
    output logic             valid_in,
    output logic             dirty_in,
    output logic             data_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    cache_state_t state, state_next;
    logic         refill;
    logic         req;
    logic         hit;
    logic         miss_go;
    logic         hit_inc;
    logic         miss_inc;
    logic         wb_inc;

    // Index and offset select array entries and bytes outside this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[CACHE_INDEX_W+CACHE_OFFSET_W-1:0];

    assign req = mem_read | mem_write;
    assign hit = valid_out & (tag_out == mem_address[15 -: TAG_W]);

    // State register; reset returns to IDLE so pmem requests drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Refill flag: marks a request that already counted as a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill <= 1'b0;
        end else if (miss_go) begin
            refill <= 1'b1;
        end else if (mem_resp) begin
            refill <= 1'b0;
        end
    end

    // Next-state and output decode; everything is quiet while rst is high.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next    = state;
        mem_resp      = 1'b0;
        data_write    = 1'b0;
        tag_write     = 1'b0;
        valid_write   = 1'b0;
        dirty_write   = 1'b0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        data_sel      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        miss_go       = 1'b0;
        wb_inc        = 1'b0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            if (mem_write) begin
                                data_write  = 1'b1;
                                data_sel    = 1'b0;
                                dirty_write = 1'b1;
                                dirty_in    = 1'b1;
                            end
                        end else begin
                            miss_go    = 1'b1;
                            state_next = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
                        end
                    end
                end

                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        wb_inc     = 1'b1;
                        state_next = ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = 1'b0;
                    if (pmem_resp) begin
                        data_write  = 1'b1;
                        data_sel    = 1'b1;
                        tag_write   = 1'b1;
                        valid_write = 1'b1;
                        valid_in    = 1'b1;
                        dirty_write = 1'b1;
                        dirty_in    = 1'b0;
                        state_next  = IDLE;
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    assign hit_inc  = mem_resp & ~refill;
    assign miss_inc = miss_go;

    lc3b_sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .clr   (stat_clear),
        .count (hit_count)
    );

    lc3b_sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .clr   (stat_clear),
        .count (miss_count)
    );

    lc3b_sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_inc),
        .clr   (stat_clear),
        .count (wb_count)
    );

endmodule

// File: tb/tb_lc3b_cache_control.sv
// Self-checking bench for lc3b_cache_control: transaction-level reference
// model with bench-owned tag/valid/dirty arrays, directed and random stimulus.
module tb_lc3b_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic [6:0]  tag_out;
    logic        valid_out, dirty_out;
    logic        pmem_resp, stat_clear;
    logic        mem_resp, data_write, tag_write, valid_write, dirty_write;
    logic        valid_in, dirty_in, data_sel;
    logic        pmem_read, pmem_write, pmem_addr_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    lc3b_cache_control #(.TAG_W(7), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .tag_out       (tag_out),
        .valid_out     (valid_out),
        .dirty_out     (dirty_out),
        .pmem_resp     (pmem_resp),
        .stat_clear    (stat_clear),
        .mem_resp      (mem_resp),
        .data_write    (data_write),
        .tag_write     (tag_write),
        .valid_write   (valid_write),
        .dirty_write   (dirty_write),
        .valid_in      (valid_in),
        .dirty_in      (dirty_in),
        .data_sel      (data_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_addr_sel (pmem_addr_sel),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Environment arrays (what the cache arrays would hold).
    logic [6:0] tag_arr   [32];
    logic       valid_arr [32];
    logic       dirty_arr [32];

    // Reference model: a request is either idle or an outstanding miss
    // that still owes a writeback and/or a fill.
    bit busy, wb_due, counted;
    int hits, misses, wbs;
    bit last_done;

    // Output bundle order: resp, dwr, twr, vwr, dirwr, vin, din, dsel, prd, pwr, psel
    function automatic logic [10:0] dut_outs();
        return {mem_resp, data_write, tag_write, valid_write, dirty_write,
                valid_in, dirty_in, data_sel, pmem_read, pmem_write, pmem_addr_sel};
    endfunction

    function automatic int sat_inc(input int v, input bit inc);
        return (inc && v < 65535) ? v + 1 : v;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input bit rd, input bit wr, input logic [15:0] addr,
                        input bit resp, input bit clr);
        logic [4:0]  idx;
        logic [6:0]  t;
        logic [10:0] exp;
        bit          req, is_hit, h_inc, m_inc, w_inc;
        idx = addr[8:4];
        t   = addr[15:9];
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        tag_out     = tag_arr[idx];
        valid_out   = valid_arr[idx];
        dirty_out   = dirty_arr[idx];
        pmem_resp   = resp;
        stat_clear  = clr;
        #2;
        check("hit_count", 32'(hit_count), 32'(hits));
        check("miss_count", 32'(miss_count), 32'(misses));
        check("wb_count", 32'(wb_count), 32'(wbs));

        exp = '0; h_inc = 0; m_inc = 0; w_inc = 0; last_done = 0;
        req    = rd | wr;
        is_hit = valid_arr[idx] && (tag_arr[idx] == t);
        if (!busy) begin
            if (req && is_hit) begin
                exp[10] = 1'b1;
                if (wr) begin
                    exp[9] = 1'b1; exp[6] = 1'b1; exp[4] = 1'b1;
                end
            end
        end else if (wb_due) begin
            exp[1] = 1'b1; exp[0] = 1'b1;
        end else begin
            exp[2] = 1'b1;
            if (resp) begin
                exp[9] = 1'b1; exp[3] = 1'b1; exp[8] = 1'b1;
                exp[7] = 1'b1; exp[5] = 1'b1; exp[6] = 1'b1;
            end
        end
        check("outputs", 32'(dut_outs()), 32'(exp));

        // Model update for the coming edge.
        if (!busy) begin
            if (req && is_hit) begin
                h_inc     = !counted;
                counted   = 0;
                last_done = 1;
                if (wr) dirty_arr[idx] = 1'b1;
            end else if (req) begin
                m_inc   = 1;
                busy    = 1;
                counted = 1;
                wb_due  = valid_arr[idx] && dirty_arr[idx];
            end
        end else if (wb_due) begin
            if (resp) begin
                w_inc  = 1;
                wb_due = 0;
            end
        end else if (resp) begin
            tag_arr[idx]   = t;
            valid_arr[idx] = 1'b1;
            dirty_arr[idx] = 1'b0;
            busy           = 0;
        end
        if (clr) begin
            hits = 0; misses = 0; wbs = 0;
        end else begin
            hits   = sat_inc(hits, h_inc);
            misses = sat_inc(misses, m_inc);
            wbs    = sat_inc(wbs, w_inc);
        end
        @(posedge clk);
        #1;
    endtask

    bit          cur_rd, cur_wr, active;
    logic [15:0] cur_addr;
    int          guard;

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_address = '0; tag_out = '0;
        valid_out = 0; dirty_out = 0; pmem_resp = 0; stat_clear = 0;
        for (int i = 0; i < 32; i++) begin
            tag_arr[i] = '0; valid_arr[i] = 1'b0; dirty_arr[i] = 1'b0;
        end
        busy = 0; wb_due = 0; counted = 0; hits = 0; misses = 0; wbs = 0;
        #12;
        check("reset_outputs", 32'(dut_outs()), 32'd0);
        check("reset_hit_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean read miss to 0x1230, fill after 4 cycles, then the hit.
        step(1, 0, 16'h1230, 0, 0);
        check("alloc_pmem_read", 32'(pmem_read), 32'd1);
        check("alloc_addr_sel", 32'(pmem_addr_sel), 32'd0);
        step(1, 0, 16'h1230, 0, 0);
        step(1, 0, 16'h1230, 0, 0);
        step(1, 0, 16'h1230, 0, 0);
        step(1, 0, 16'h1230, 1, 0);
        step(1, 0, 16'h1230, 0, 0);
        check("clean_miss_count", 32'(miss_count), 32'd1);
        check("clean_hit_count", 32'(hit_count), 32'd0);

        // Repeat read hits, then a write hit dirties the line.
        step(1, 0, 16'h1230, 0, 0);
        check("read_hit_count", 32'(hit_count), 32'd1);
        step(0, 1, 16'h1230, 0, 0);
        check("write_hit_count", 32'(hit_count), 32'd2);

        // Dirty conflict miss at 0x4230: writeback then allocate.
        step(1, 0, 16'h4230, 0, 0);
        check("wb_pmem_write", 32'(pmem_write), 32'd1);
        check("wb_addr_sel", 32'(pmem_addr_sel), 32'd1);
        step(1, 0, 16'h4230, 0, 0);
        step(1, 0, 16'h4230, 1, 0);
        step(1, 0, 16'h4230, 0, 0);
        step(1, 0, 16'h4230, 1, 0);
        step(1, 0, 16'h4230, 0, 0);
        check("dirty_wb_count", 32'(wb_count), 32'd1);
        check("dirty_miss_count", 32'(miss_count), 32'd2);

        // Reset in the middle of ALLOCATE.
        step(1, 0, 16'h5230, 0, 0);
        step(1, 0, 16'h5230, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_outputs", 32'(dut_outs()), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        check("rst_wb_count", 32'(wb_count), 32'd0);
        busy = 0; wb_due = 0; counted = 0; hits = 0; misses = 0; wbs = 0;
        mem_read = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic over a few tags and indices to force conflicts.
        for (int i = 0; i < 32; i++) begin
            tag_arr[i]   = 7'($urandom_range(0, 3));
            valid_arr[i] = 1'($urandom);
            dirty_arr[i] = 1'($urandom);
        end
        active = 0; last_done = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!busy && (!active || last_done)) begin
                active   = ($urandom_range(0, 3) != 0);
                cur_rd   = active && 1'($urandom);
                cur_wr   = active && (!cur_rd || ($urandom_range(0, 3) == 0));
                cur_addr = {7'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 4'($urandom)};
            end
            step(cur_rd, cur_wr, cur_addr, busy && ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 49) == 0);
        end
        guard = 0;
        while (busy && guard < 10) begin
            step(cur_rd, cur_wr, cur_addr, 1, 0);
            guard++;
        end
        check("drain_done", 32'(busy), 32'd0);

        // Saturation: clear, then more hits than the counter can hold.
        tag_arr[3] = 7'h09; valid_arr[3] = 1'b1;
        step(1, 0, 16'h1230, 0, 1);
        for (int n = 0; n < 65540; n++) step(1, 0, 16'h1230, 0, 0);
        check("sat_hit_count", 32'(hit_count), 32'hFFFF);
        step(1, 0, 16'h1230, 0, 1);
        check("clear_over_hit", 32'(hit_count), 32'd0);
        step(0, 0, 16'h0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
